// File: rtl/rxrbcnt_fifo_mc_pkg.sv
// ----------------------------------------------------------------------------
// rxrbcnt_fifo_mc_pkg
// Shared defaults for the multi-channel receive byte-count FIFO and a helper
// that locates one channel's occupancy field inside the packed usedw bus.
// ----------------------------------------------------------------------------
package rxrbcnt_fifo_mc_pkg;

    localparam int DEF_WIDTH = 32;  // byte-count word width
    localparam int DEF_DEPTH = 4;   // entries per channel (power of two)
    localparam int DEF_PTR   = 2;   // log2(DEF_DEPTH)
    localparam int DEF_NCH   = 4;   // number of channels
    localparam int DEF_CHW   = 2;   // channel index width
    localparam int DEF_AFULL = 3;   // almost-full threshold

    // LSB of channel ch's occupancy field; each field is ptr+1 bits wide.
    function automatic int usedw_lsb(input int ch, input int ptr);
        return ch * (ptr + 1);
    endfunction

endpackage

// File: rtl/rxrbcnt_fifo_mc_sfifo.sv
// ----------------------------------------------------------------------------
// rxrbcnt_fifo_mc_sfifo
// Single-channel synchronous FIFO with a registered read port and sticky
// overflow/underflow flags.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    push request and word
//   rd_en             pop request
//   clr_err           clears ovf/udf (a new error in the same cycle wins)
//   rd_data, rd_valid popped word (held until the next pop), 1-cycle pulse
//   usedw             occupancy (wptr - rptr)
//   full/empty/afull  occupancy flags, combinational from the pointers
//   ovf, udf          sticky error flags
// ----------------------------------------------------------------------------
module rxrbcnt_fifo_mc_sfifo
    import rxrbcnt_fifo_mc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR   = DEF_PTR,
    parameter int AFULL = DEF_AFULL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [PTR:0]     usedw,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             ovf,
    output logic             udf
);

    localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AFULL_W = (PTR+1)'(AFULL);
    localparam logic [PTR:0] ONE_W   = (PTR+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR:0]     wptr_r;
    logic [PTR:0]     rptr_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r;
    logic             ovf_r;
    logic             udf_r;

    logic [PTR:0]     usedw_s;
    logic             full_s;
    logic             empty_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             ovf_set_s;
    logic             udf_set_s;

    // Occupancy flags and accept/error decisions for this cycle.
    always_comb begin
        usedw_s   = wptr_r - rptr_r;
        full_s    = (usedw_s == DEPTH_W);
        empty_s   = (usedw_s == '0);
        rd_ok_s   = rd_en & ~empty_s;
        // A full queue still takes a write when the same cycle pops a slot;
        // the write lands on the slot being read, which the read sees old.
        wr_ok_s   = wr_en & (~full_s | rd_ok_s);
        ovf_set_s = wr_en & full_s & ~rd_ok_s;
        udf_set_s = rd_en & empty_s;
    end

    // Entry storage; cleared on reset so discarded data never reappears.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_r[wptr_r[PTR-1:0]] <= wr_data;
        end
    end

    // Pointers and the registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
            if (wr_ok_s) begin
                wptr_r <= wptr_r + ONE_W;
            end
            if (rd_ok_s) begin
                rptr_r    <= rptr_r + ONE_W;
                rd_data_r <= mem_r[rptr_r[PTR-1:0]];
            end
        end
    end

    // Sticky error flags; a fresh error outranks clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (clr_err) begin
            ovf_r <= ovf_set_s;
            udf_r <= udf_set_s;
        end else begin
            ovf_r <= ovf_r | ovf_set_s;
            udf_r <= udf_r | udf_set_s;
        end
    end

    assign usedw    = usedw_s;
    assign full     = full_s;
    assign empty    = empty_s;
    assign afull    = (usedw_s >= AFULL_W);
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign ovf      = ovf_r;
    assign udf      = udf_r;

endmodule

// File: rtl/rxrbcnt_fifo_mc.sv
// ----------------------------------------------------------------------------
// rxrbcnt_fifo_mc
// NCH independent DEPTH x WIDTH byte-count queues sharing one write port and
// one read port, each addressed by a channel index.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   wren, wrch, datain  write request, target channel, word
//   rden, rdch          read request, source channel
//   dataout, rdvalid    popped word (registered, held), 1-cycle valid pulse
//   full/empty/afull    per-channel occupancy flags
//   usedw               packed occupancy, channel c at [c*(PTR+1) +: PTR+1]
//   ovf, udf            per-channel sticky overflow / underflow
//   clr_err             clears all sticky bits
//   dbg                 registered: any sticky error or a bad channel index
// ----------------------------------------------------------------------------
module rxrbcnt_fifo_mc
    import rxrbcnt_fifo_mc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR   = DEF_PTR,
    parameter int NCH   = DEF_NCH,
    parameter int CHW   = DEF_CHW,
    parameter int AFULL = DEF_AFULL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wren,
    input  logic [CHW-1:0]         wrch,
    input  logic [WIDTH-1:0]       datain,
    input  logic                   rden,
    input  logic [CHW-1:0]         rdch,
    output logic [WIDTH-1:0]       dataout,
    output logic                   rdvalid,
    output logic [NCH-1:0]         full,
    output logic [NCH-1:0]         empty,
    output logic [NCH-1:0]         afull,
    output logic [NCH*(PTR+1)-1:0] usedw,
    output logic [NCH-1:0]         ovf,
    output logic [NCH-1:0]         udf,
    input  logic                   clr_err,
    output logic                   dbg
);

    localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

    logic [NCH-1:0]   wr_sel_s;
    logic [NCH-1:0]   rd_sel_s;
    logic [WIDTH-1:0] ch_rdata_s [NCH];
    logic [NCH-1:0]   ch_rvalid_s;
    logic             bad_idx_s;
    logic             rd_hit_s;
    logic [CHW-1:0]   last_rdch_r;
    logic             dbg_r;

    // Channel decode; an out-of-range index selects no queue at all.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wr_sel_s[c] = wren & (wrch == CHW'(c));
            rd_sel_s[c] = rden & (rdch == CHW'(c));
        end
        bad_idx_s = (wren & ({1'b0, wrch} >= NCH_W)) |
                    (rden & ({1'b0, rdch} >= NCH_W));
        rd_hit_s  = |(rd_sel_s & ~empty);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        rxrbcnt_fifo_mc_sfifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .PTR   (PTR),
            .AFULL (AFULL)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_sel_s[c]),
            .wr_data  (datain),
            .rd_en    (rd_sel_s[c]),
            .clr_err  (clr_err),
            .rd_data  (ch_rdata_s[c]),
            .rd_valid (ch_rvalid_s[c]),
            .usedw    (usedw[usedw_lsb(c, PTR) +: (PTR+1)]),
            .full     (full[c]),
            .empty    (empty[c]),
            .afull    (afull[c]),
            .ovf      (ovf[c]),
            .udf      (udf[c])
        );
    end

    // Remember the channel of the last accepted pop; its held word is what
    // dataout shows, so failed reads leave dataout untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_rdch_r <= '0;
        end else if (rd_hit_s) begin
            last_rdch_r <= rdch;
        end
    end

    // Debug pulse: sticky errors present or a request with a bad index.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_r <= 1'b0;
        end else begin
            dbg_r <= (|ovf) | (|udf) | bad_idx_s;
        end
    end

    // Select the held word of the last popped channel (AND-OR mux).
    always_comb begin
        dataout = '0;
        for (int c = 0; c < NCH; c++) begin
            dataout = dataout | (ch_rdata_s[c] & {WIDTH{last_rdch_r == CHW'(c)}});
        end
    end

    assign rdvalid = |ch_rvalid_s;
    assign dbg     = dbg_r;

endmodule

// File: tb/tb_rxrbcnt_fifo_mc.sv
// ----------------------------------------------------------------------------
// tb_rxrbcnt_fifo_mc
// Scoreboard bench: each stimulus cycle updates a queue-based reference model
// and pushes the expected post-edge outputs; a monitor pops one entry after
// every clock edge and compares. CHW is widened to 3 so indices 4..7 exist.
// ----------------------------------------------------------------------------
module tb_rxrbcnt_fifo_mc;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int PTR   = 2;
    localparam int NCH   = 4;
    localparam int CHW   = 3;
    localparam int AFULL = 3;
    localparam int UW    = NCH * (PTR + 1);

    logic             clk = 1'b0;
    logic             reset, wren, rden, clr_err;
    logic [CHW-1:0]   wrch, rdch;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    logic             rdvalid, dbg;
    logic [NCH-1:0]   full, empty, afull, ovf, udf;
    logic [UW-1:0]    usedw;

    always #5 clk = ~clk;

    rxrbcnt_fifo_mc #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR),
        .NCH(NCH), .CHW(CHW), .AFULL(AFULL)
    ) dut (
        .clk(clk), .reset(reset), .wren(wren), .wrch(wrch), .datain(datain),
        .rden(rden), .rdch(rdch), .dataout(dataout), .rdvalid(rdvalid),
        .full(full), .empty(empty), .afull(afull), .usedw(usedw),
        .ovf(ovf), .udf(udf), .clr_err(clr_err), .dbg(dbg)
    );

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [NCH-1:0]   full;
        logic [NCH-1:0]   empty;
        logic [NCH-1:0]   afull;
        logic [NCH-1:0]   ovf;
        logic [NCH-1:0]   udf;
        logic [UW-1:0]    usedw;
        logic             dbg;
    } exp_t;

    typedef logic [WIDTH-1:0] word_t;

    exp_t     exp_q[$];
    word_t    mq [NCH][$];
    logic [NCH-1:0] m_ovf = '0;
    logic [NCH-1:0] m_udf = '0;
    word_t    m_hold = '0;
    int       errors = 0;
    int       checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced with the same inputs.
    task automatic step(input logic rst, input logic w, input int wc, input word_t d,
                        input logic r, input int rc, input logic clr);
        exp_t e;
        logic [NCH-1:0] os;
        logic [NCH-1:0] us;
        int n;
        @(negedge clk);
        reset   = rst;
        wren    = w;
        wrch    = wc[CHW-1:0];
        datain  = d;
        rden    = r;
        rdch    = rc[CHW-1:0];
        clr_err = clr;
        e  = '0;
        os = '0;
        us = '0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_ovf  = '0;
            m_udf  = '0;
            m_hold = '0;
        end else begin
            e.dbg = (|m_ovf) | (|m_udf) | (w && wc >= NCH) | (r && rc >= NCH);
            // Read first, then write: a pop frees the slot a same-cycle write
            // may use, and an empty read never sees the same-cycle write.
            if (r && rc < NCH) begin
                if (mq[rc].size() > 0) begin
                    m_hold  = mq[rc].pop_front();
                    e.valid = 1'b1;
                end else begin
                    us[rc] = 1'b1;
                end
            end
            if (w && wc < NCH) begin
                if (mq[wc].size() < DEPTH) mq[wc].push_back(d);
                else                       os[wc] = 1'b1;
            end
            if (clr) begin
                m_ovf = os;
                m_udf = us;
            end else begin
                m_ovf = m_ovf | os;
                m_udf = m_udf | us;
            end
        end
        e.data = m_hold;
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        for (int c = 0; c < NCH; c++) begin
            n = mq[c].size();
            e.full[c]  = (n == DEPTH);
            e.empty[c] = (n == 0);
            e.afull[c] = (n >= AFULL);
            e.usedw[c*(PTR+1) +: (PTR+1)] = n[PTR:0];
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compare everything one time unit after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdvalid", 64'(rdvalid), 64'(e.valid));
                chk("dataout", 64'(dataout), 64'(e.data));
                chk("full",    64'(full),    64'(e.full));
                chk("empty",   64'(empty),   64'(e.empty));
                chk("afull",   64'(afull),   64'(e.afull));
                chk("usedw",   64'(usedw),   64'(e.usedw));
                chk("ovf",     64'(ovf),     64'(e.ovf));
                chk("udf",     64'(udf),     64'(e.udf));
                chk("dbg",     64'(dbg),     64'(e.dbg));
            end
        end
    end

    initial begin
        logic w, r, clr, rst;
        int wc, rc;
        reset = 1'b1; wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
        wrch = '0; rdch = '0; datain = '0;

        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);

        // ch1: three writes, three reads in order
        step(1'b0, 1'b1, 1, 32'h40,  1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1, 32'h5EE, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1, 32'h3C,  1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 32'h0, 1'b1, 1, 1'b0);
        idle();

        // ch2: fill, overflow write, drain
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2, 32'h200 + 32'(i), 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 32'h0, 1'b1, 2, 1'b0);

        // ch0: underflow, clear, then clear racing a new underflow
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b1);

        // ch3: full with simultaneous push/pop, ten iterations, then drain
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3, 32'h300 + 32'(i), 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3, 32'h3A0 + 32'(i), 1'b1, 3, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 32'h0, 1'b1, 3, 1'b0);

        // independent channels: write ch0 while reading ch1; bad indices
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1, 32'h110 + 32'(i), 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0, 32'h100 + 32'(i), 1'b1, 1, 1'b0);
        step(1'b0, 1'b1, 5, 32'hDEAD, 1'b0, 0, 1'b0);
        idle();
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 6, 1'b0);
        idle();

        // reset with ch0 holding 3 words and rden high
        step(1'b1, 1'b0, 0, 32'h0, 1'b1, 0, 1'b0);
        idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            w   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            wc  = ($urandom_range(0, 9) == 0) ? 4 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            rc  = ($urandom_range(0, 9) == 0) ? 4 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step(rst, w, wc, word_t'($urandom), r, rc, clr);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
